// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Optional early exit is enabled by SEQ_MULTIPLIER_EARLY_EXIT_EN.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 5;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Accumulator, shifting multiplicand/multiplier and the add step.
// SEQ_MULTIPLIER_EARLY_EXIT_EN adds the multiplier-exhausted flag.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               early
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    // Set when the multiplier becomes zero after this edge's shift.
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    assign early = (mplier[WIDTH-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned multiplier with start/busy/done handshake.
// SEQ_MULTIPLIER_EARLY_EXIT_EN: finish once the multiplier is exhausted.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               load;
    logic               step;
    logic               early;
    logic               last;
    logic [2*WIDTH-1:0] acc_nxt;

    assign load = start && (state == ST_IDLE || state == ST_DONE);
    assign step = (state == ST_BUSY);
    assign last = (cnt == CNT_LAST) || early;

    seq_mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .a       (a),
        .b       (b),
        .acc_nxt (acc_nxt),
        .early   (early)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    cnt  <= '0;
                    if (start) begin
                        state <= ST_BUSY;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        product  <= acc_nxt;
                        overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add unsigned multiplier; sequential successor to the fixed 5-bit combinational multiplier.
- Takes WIDTH-bit operands a and b and produces a full 2*WIDTH-bit product over multiple cycles.
- Uses a start/busy/done handshake, so it can sit behind the ALU or a control FSM without a wide combinational array.

Parameters:
- WIDTH, 5, operand width in bits; legal range 2..32.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- a  input  WIDTH  multiplicand; latched on the accepting edge.
- b  input  WIDTH  multiplier; latched on the accepting edge.
- busy  output  1  high while state is BUSY.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.
- product  output  2*WIDTH  full unsigned product; held until the next accepted start.
- overflow  output  1  high when product[2*WIDTH-1:WIDTH] is nonzero (result does not fit in WIDTH bits); same timing as product.

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, product 0, overflow 0, internal accumulator/counter 0.
- Reset applies at any time, including mid-operation: the operation is aborted and no done pulse is produced.
- States:
  - IDLE: start=1 latches a into mcand (zero-extended to 2*WIDTH) and b into mplier, clears acc, clears cnt, goes to BUSY.
  - BUSY: each edge, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt += 1. When cnt reaches WIDTH-1 on that edge (the WIDTH-th iteration), load product with the final acc, set overflow, go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted on edge N -> done and product valid after edge N+WIDTH (WIDTH cycles).
- start while BUSY is ignored; operand inputs are don't-care outside the accepting edge.
- product and overflow change only on the DONE-entry edge or on reset. The accepting edge does not clear product.
- Arithmetic: the accumulator is 2*WIDTH bits and never overflows; no truncation of the product.
- a=0 or b=0: full latency without the optional feature, product 0.
- cnt width is clog2(WIDTH).

Optional Feature:
- Macro: SEQ_MULTIPLIER_EARLY_EXIT_EN.
- Defined: in BUSY, if the shifted mplier is zero after the current edge's update, finish on that edge (load product, go to DONE).
  - Latency is 1..WIDTH cycles and equals the bit position of b's highest set bit plus 1.
  - b=0 gives latency 1.
- Undefined: fixed WIDTH-cycle latency, with no mplier-zero comparator logic.

Decomposition:
- Package seq_mult_pkg:
  - state encoding (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2);
  - cnt-width helper function;
  - default WIDTH constant.
- One natural sub-module, seq_mult_datapath: the acc/mcand/mplier registers and adder, with load/step control inputs.
- The FSM, counter and handshake stay in seq_multiplier.

Test Plan (WIDTH=5 unless noted):
- Reset then idle: reset held 2 cycles -> busy=0, done=0, product=10'h000, overflow=0; no done pulse while start=0.
- Basic: a=3, b=7, start one cycle -> busy for 5 cycles, done pulse 5 edges later, product=21 (10'h015), overflow=0; product held after done.
- Max operands: a=31, b=31 -> product=961 (10'h3C1), overflow=1. Also a=2, b=0 -> product=0 with full 5-cycle latency (macro off).
- Handshake edges:
  - start pulsed again while busy with a=1, b=1 -> ignored; first result 3*7=21 unchanged.
  - start asserted in the DONE cycle with a=5, b=6 -> accepted, next done gives 30.
- Reset mid-operation: start with a=9, b=9, assert reset on the 3rd BUSY cycle -> state IDLE, product=0, no done pulse. A new 4*4 operation then gives 16.
- Early exit (macro on): a=13, b=1 -> done after 1 cycle, product=13. a=13, b=16 -> 5 cycles, product=208. Macro off: both take 5 cycles with the same products.
- Parameter sweep WIDTH=8: 255*255 -> product 16'hFE01, overflow=1, latency 8 cycles. Random operands checked against a*b in the bench.
